// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority arbiter.
//   arb_mode_e : arbitration mode encoding (fixed priority or round-robin)
//   ring_add   : modular index addition used to rotate/un-rotate the request ring
package rr_priority_arbiter_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  function automatic int ring_add(input int base, input int offs, input int n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_prio_enc_n.sv
// Combinational N-input priority encoder (highest set index wins).
// Ports:
//   vec  in  N  input vector
//   idx  out W  index of the highest set bit, 0 when vec is all-zero
//   any  out 1  1 when any bit of vec is set
module prio_enc_n
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with fixed-priority and round-robin modes.
// Grants are held until the holder releases or drops its request; in
// round-robin mode a grant is also forcibly re-arbitrated after HOLD_MAX cycles.
// Ports:
//   clk            in   1  rising-edge clock
//   reset          in   1  asynchronous active-high reset
//   req            in   N  request vector, bit i = requester i
//   rr_mode        in   1  0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   release_grant  in   1  one-cycle pulse: current holder gives up the grant
//   grant          out  N  registered one-hot grant, zero when idle
//   grant_idx      out  W  registered binary index of the holder, zero when idle
//   valid          out  1  registered, high while a grant is held
module rr_priority_arbiter
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = $clog2(N),
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  input  logic         release_grant,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid
);

  localparam int            CW        = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [N-1:0]  ONE       = N'(1);

  logic [W-1:0]  rr_ptr;
  logic [CW-1:0] hold_cnt;
  arb_mode_e     hold_mode;

  logic [W-1:0]  fix_idx;
  logic          fix_any;
  logic [N-1:0]  rr_vec;
  logic [W-1:0]  rr_k;
  logic          rr_any;
  logic [W-1:0]  rr_idx;
  logic [W-1:0]  win_idx;
  logic          win_any;
  logic          arb;

  prio_enc_n #(.N(N), .W(W)) u_enc_fix (
    .vec (req),
    .idx (fix_idx),
    .any (fix_any)
  );

  // Rotate req so that position rr_ptr+1 comes first, then bit-reverse it:
  // the "first set bit searching upward" becomes the highest set bit, which
  // the shared highest-wins encoder can find.
  always_comb begin
    rr_vec = '0;
    for (int j = 0; j < N; j++) begin
      rr_vec[N-1-j] = req[ring_add(int'(rr_ptr), 1 + j, N)];
    end
  end

  prio_enc_n #(.N(N), .W(W)) u_enc_rr (
    .vec (rr_vec),
    .idx (rr_k),
    .any (rr_any)
  );

  // Un-rotate: offset j = N-1-k from rr_ptr+1 gives rr_ptr + N - k (mod N).
  assign rr_idx  = W'(ring_add(int'(rr_ptr), N - int'(rr_k), N));
  assign win_idx = (rr_mode == MODE_RR) ? rr_idx : fix_idx;
  assign win_any = (rr_mode == MODE_RR) ? rr_any : fix_any;

  // The hold limit follows the mode the current grant was issued under, so a
  // mode change mid-grant only takes effect at the next arbitration.
  assign arb = !valid
            || !req[grant_idx]
            || release_grant
            || ((hold_mode == MODE_RR) && (hold_cnt == HOLD_LAST));

  // Arbitration stage -> registered grant, pointer and hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      grant_idx <= '0;
      valid     <= 1'b0;
      hold_cnt  <= '0;
      hold_mode <= MODE_FIXED;
      rr_ptr    <= W'(N - 1);
    end else if (arb) begin
      hold_cnt <= '0;
      if (win_any) begin
        grant     <= ONE << win_idx;
        grant_idx <= win_idx;
        valid     <= 1'b1;
        hold_mode <= arb_mode_e'(rr_mode);
        if (rr_mode == MODE_RR) rr_ptr <= win_idx;
      end else begin
        grant     <= '0;
        grant_idx <= '0;
        valid     <= 1'b0;
      end
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         rr_mode;
  logic         rel;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         valid;

  int checks   = 0;
  int failures = 0;

  rr_priority_arbiter #(.N(N), .HOLD_MAX(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .rr_mode       (rr_mode),
    .release_grant (rel),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] g, input logic [W-1:0] i,
                           input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".idx"}, 32'(grant_idx), 32'(i));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic ok;
    reset   = 1'b1;
    req     = '0;
    rr_mode = 1'b0;
    rel     = 1'b0;

    // Reset state
    #1;
    check_out("reset_init", 4'b0000, 2'd0, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Fixed priority: highest index wins, then falls to the next on drop
    req = 4'b0101;
    step();
    check_out("fix_0101", 4'b0100, 2'd2, 1'b1);
    req = 4'b0001;
    step();
    check_out("fix_drop2", 4'b0001, 2'd0, 1'b1);

    // Asynchronous reset mid-grant, visible before the next edge
    reset = 1'b1;
    #1;
    check_out("reset_async", 4'b0000, 2'd0, 1'b0);
    step();
    check_out("reset_held", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    req   = 4'b0000;

    // Idle and release behaviour
    step();
    check_out("idle", 4'b0000, 2'd0, 1'b0);
    rel = 1'b1;
    step();
    check_out("idle_rel", 4'b0000, 2'd0, 1'b0);
    rel = 1'b0;
    req = 4'b1000;
    step();
    check_out("single3", 4'b1000, 2'd3, 1'b1);
    rel = 1'b1;
    step();
    check_out("regrant3", 4'b1000, 2'd3, 1'b1);
    rel = 1'b0;
    step();
    check_out("hold3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    step();
    check_out("drop_idle", 4'b0000, 2'd0, 1'b0);
    rel = 1'b1;
    step();
    check_out("rel_invalid", 4'b0000, 2'd0, 1'b0);
    rel = 1'b0;

    // Round-robin fairness with release every cycle
    pulse_reset();
    rr_mode = 1'b1;
    req     = 4'b1111;
    step();
    check("rr_fair0", 32'(grant_idx), 32'd0);
    rel = 1'b1;
    step();
    check("rr_fair1", 32'(grant_idx), 32'd1);
    step();
    check("rr_fair2", 32'(grant_idx), 32'd2);
    step();
    check_out("rr_fair3", 4'b1000, 2'd3, 1'b1);
    step();
    check("rr_fair4", 32'(grant_idx), 32'd0);
    rel = 1'b0;

    // Hold limit: 8 cycles per holder with no release
    pulse_reset();
    rr_mode = 1'b1;
    req     = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("hold_a%0d", c), 32'(grant_idx), 32'd0);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("hold_b%0d", c), 32'(grant_idx), 32'd1);
    end
    step();
    check("hold_wrap", 32'(grant_idx), 32'd0);

    // Mode switch mid-grant, and rr pointer preserved across fixed grants
    pulse_reset();
    rr_mode = 1'b1;
    req     = 4'b0010;
    step();
    check_out("ms_rr1", 4'b0010, 2'd1, 1'b1);
    rr_mode = 1'b0;
    req     = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("ms_hold%0d", c), 32'(grant_idx), 32'd1);
    end
    rel = 1'b1;
    step();
    check_out("ms_fix3", 4'b1000, 2'd3, 1'b1);
    rr_mode = 1'b1;
    req     = 4'b1111;
    step();
    check("ms_ptr_kept", 32'(grant_idx), 32'd2);
    rel = 1'b0;

    // Random run: structural invariant every cycle
    for (int c = 0; c < 300; c++) begin
      req     = 4'($urandom_range(0, 15));
      rel     = 1'($urandom_range(0, 3) == 0);
      rr_mode = 1'($urandom_range(0, 1));
      step();
      if (valid) ok = $onehot(grant) && grant[grant_idx];
      else       ok = (grant == 4'b0000) && (grant_idx == 2'd0);
      check($sformatf("invariant%0d", c), 32'(ok), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
